settings_wb_arbiter: RTL and testbench

- Round-robin Wishbone arbiter that shares the single game-settings slave (the main FSM's setup memory) between up to NUM_MASTERS requesters, e.g. draw_board, the mouse/cell handler and the timer block.
- A granted master owns the bus for its whole cycle, so multi-register burst reads stay atomic.
- A watchdog aborts strobes the slave never acks.

---
 rtl/settings_wb_arbiter_if.sv | 42 ++++
 rtl/settings_wb_arbiter.sv | 112 +++++++++++
 tb/tb_settings_wb_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/settings_wb_arbiter_if.sv
// Wishbone bundle between the game-settings requesters, the arbiter and the setup-memory slave.
// Master-side signals are packed per requester; slave-side signals are the single shared port.
interface settings_wb_arbiter_if #(
    parameter int NUM_MASTERS = 3,
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 16
);
    logic [NUM_MASTERS-1:0]            m_cyc;
    logic [NUM_MASTERS-1:0]            m_stb;
    logic [NUM_MASTERS-1:0]            m_we;
    logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr;
    logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_w;
    logic [DATA_WIDTH-1:0]             m_dat_r;
    logic [NUM_MASTERS-1:0]            m_ack;
    logic [NUM_MASTERS-1:0]            m_err;

    logic                              s_cyc;
    logic                              s_stb;
    logic                              s_we;
    logic [ADDR_WIDTH-1:0]             s_adr;
    logic [DATA_WIDTH-1:0]             s_dat_w;
    logic [DATA_WIDTH-1:0]             s_dat_r;
    logic                              s_ack;

    // Requester side: drives requests, receives responses.
    modport master (
        output m_cyc, m_stb, m_we, m_adr, m_dat_w,
        input  m_dat_r, m_ack, m_err
    );

    // Settings slave side: receives the muxed bus, returns data and ack.
    modport slave (
        input  s_cyc, s_stb, s_we, s_adr, s_dat_w,
        output s_dat_r, s_ack
    );

    // Arbiter view: sits between all requesters and the slave.
    modport arbiter (
        input  m_cyc, m_stb, m_we, m_adr, m_dat_w, s_dat_r, s_ack,
        output m_dat_r, m_ack, m_err, s_cyc, s_stb, s_we, s_adr, s_dat_w
    );
endinterface

// File: rtl/settings_wb_arbiter.sv
// Round-robin Wishbone arbiter sharing the game-settings slave between several requesters.
// The owner keeps the bus for its whole cycle; a watchdog aborts strobes that are never acked.
module settings_wb_arbiter #(
    parameter int NUM_MASTERS = 3,
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 16,
    parameter int TIMEOUT     = 15
) (
    input  logic                           clk,
    input  logic                           rst,
    settings_wb_arbiter_if.arbiter         bus,
    output logic [$clog2(NUM_MASTERS)-1:0] grant_id,
    output logic                           busy
);
    localparam int GW = $clog2(NUM_MASTERS);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, OWNED, RELEASE} state_t;

    state_t                 state_reg;
    logic [GW-1:0]          grant_reg;
    logic [GW-1:0]          last_grant_reg;
    logic [TW-1:0]          wd_cnt_reg;
    logic [NUM_MASTERS-1:0] err_reg;

    logic [GW-1:0]          cand_idx [NUM_MASTERS];
    logic [NUM_MASTERS-1:0] cand_req;
    logic [GW-1:0]          pick;
    logic                   pick_valid;

    logic owned;
    logic owner_cyc;
    logic cyc_int;
    logic stb_int;
    logic ack_fwd;

    // Candidate gi is the master gi+1 places after the last winner.
    generate
        for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_cand
            assign cand_idx[gi] = GW'((int'(last_grant_reg) + 1 + gi) % NUM_MASTERS);
            assign cand_req[gi] = bus.m_cyc[cand_idx[gi]];
            assign bus.m_ack[gi] = ack_fwd && (grant_reg == GW'(gi));
        end
    endgenerate

    always_comb begin
        pick       = cand_idx[0];
        pick_valid = 1'b0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            if (cand_req[k]) begin
                pick       = cand_idx[k];
                pick_valid = 1'b1;
            end
        end
    end

    assign owned     = (state_reg == OWNED);
    assign owner_cyc = bus.m_cyc[grant_reg];
    assign cyc_int   = owned && owner_cyc;
    assign stb_int   = cyc_int && bus.m_stb[grant_reg];
    // An ack during the cycle the owner lets go, or during reset, is swallowed.
    assign ack_fwd   = cyc_int && bus.s_ack && !rst;

    assign bus.s_cyc   = cyc_int;
    assign bus.s_stb   = stb_int;
    assign bus.s_we    = owned && bus.m_we[grant_reg];
    assign bus.s_adr   = owned ? bus.m_adr[grant_reg*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    assign bus.s_dat_w = owned ? bus.m_dat_w[grant_reg*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign bus.m_dat_r = owned ? bus.s_dat_r : '0;
    assign bus.m_err   = err_reg;
    assign grant_id    = grant_reg;
    assign busy        = owned;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            grant_reg      <= '0;
            last_grant_reg <= GW'(NUM_MASTERS - 1);
            wd_cnt_reg     <= '0;
            err_reg        <= '0;
        end else begin
            err_reg <= '0;
            case (state_reg)
                IDLE: begin
                    if (pick_valid) begin
                        grant_reg      <= pick;
                        last_grant_reg <= pick;
                        wd_cnt_reg     <= '0;
                        state_reg      <= OWNED;
                    end
                end
                OWNED: begin
                    if (!owner_cyc) begin
                        state_reg <= RELEASE;
                    end else if (bus.s_ack) begin
                        wd_cnt_reg <= '0;
                    end else if (stb_int) begin
                        // Limit reached with no ack: abort and signal the owner.
                        if (wd_cnt_reg == TW'(TIMEOUT - 1)) begin
                            err_reg[grant_reg] <= 1'b1;
                            state_reg          <= RELEASE;
                        end else begin
                            wd_cnt_reg <= wd_cnt_reg + 1'b1;
                        end
                    end
                end
                RELEASE: state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_settings_wb_arbiter.sv
// Scoreboard bench for settings_wb_arbiter: stimulus queues expected responses,
// a negedge monitor pops and compares each ack/err the arbiter presents.
module tb_settings_wb_arbiter;
    localparam int NM = 3;
    localparam int AW = 8;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst;
    logic [NM-1:0]    m_cyc_v;
    logic [NM-1:0]    m_stb_v;
    logic [NM-1:0]    m_we_v;
    logic [NM*AW-1:0] m_adr_v;
    logic [NM*DW-1:0] m_dat_w_v;
    logic [1:0]       grant_id;
    logic             busy;
    int               ack_delay;
    bit               force_ack;
    int               scnt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          m;
        bit          err;
        logic [15:0] data;
    } exp_t;
    exp_t exp_q[$];

    settings_wb_arbiter_if #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    settings_wb_arbiter #(
        .NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(15)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .grant_id (grant_id),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rdata(input logic [7:0] a);
        return {~a, a};
    endfunction

    assign bus.m_cyc   = m_cyc_v;
    assign bus.m_stb   = m_stb_v;
    assign bus.m_we    = m_we_v;
    assign bus.m_adr   = m_adr_v;
    assign bus.m_dat_w = m_dat_w_v;

    // Slave: returns rdata(adr) and acks after ack_delay wait cycles of a continuous strobe.
    assign bus.s_dat_r = rdata(bus.s_adr);
    assign bus.s_ack   = force_ack || (bus.s_cyc && bus.s_stb && (scnt == ack_delay));

    always @(posedge clk) begin
        if (rst || !(bus.s_cyc && bus.s_stb) || bus.s_ack) scnt <= 0;
        else scnt <= scnt + 1;
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < NM; i++) begin
            if (bus.m_ack[i] || bus.m_err[i]) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_resp: master %0d ack=%b err=%b, required no response",
                             i, bus.m_ack[i], bus.m_err[i]);
                end else begin
                    e = exp_q.pop_front();
                    if (e.m != i || e.err != bus.m_err[i] || bus.m_ack[i] == e.err ||
                        (!e.err && bus.m_dat_r !== e.data)) begin
                        errors++;
                        $display("FAIL resp: got master %0d ack=%b err=%b data=%h, required master %0d err=%b data=%h",
                                 i, bus.m_ack[i], bus.m_err[i], bus.m_dat_r, e.m, e.err, e.data);
                    end else begin
                        $display("resp: master %0d err=%b data=%h ok", i, e.err, bus.m_dat_r);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic push(input int m, input bit e, input logic [7:0] a);
        exp_t x;
        x.m = m; x.err = e; x.data = rdata(a);
        exp_q.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int m, input logic [7:0] a, input bit we);
        m_adr_v[m*AW +: AW]   = a;
        m_dat_w_v[m*DW +: DW] = {a, ~a};
        m_we_v[m]  = we;
        m_cyc_v[m] = 1'b1;
        m_stb_v[m] = 1'b1;
    endtask

    task automatic stop(input int m);
        m_cyc_v[m] = 1'b0;
        m_stb_v[m] = 1'b0;
        m_we_v[m]  = 1'b0;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Waits (bounded) for ack or err on master m; n = negedges elapsed, 0 on timeout.
    task automatic wait_resp(input int m, output bit got_err, output int n);
        got_err = 1'b0;
        n = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (bus.m_ack[m] || bus.m_err[m]) begin
                got_err = bus.m_err[m];
                n = k;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL wait_resp: master %0d got no response, required one within 100 cycles", m);
    endtask

    task automatic master_proc(input int m);
        bit e;
        int n;
        for (int r = 0; r < 2; r++) begin
            start(m, 8'h30 + 8'(m * 4 + r), 1'b0);
            wait_resp(m, e, n);
            chk("rr_grant_id", 32'(grant_id), m);
            tick();
            stop(m);
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        bit e;
        int n;
        int gap;
        int start_n;
        int err_n;

        rst = 1'b1;
        m_cyc_v = '0; m_stb_v = '0; m_we_v = '0; m_adr_v = '0; m_dat_w_v = '0;
        ack_delay = 0;
        force_ack = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_cyc", 32'(bus.s_cyc), 0);
        chk("rst_s_stb", 32'(bus.s_stb), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_grant_id", 32'(grant_id), 0);
        chk("rst_m_ack", 32'(bus.m_ack), 0);
        chk("rst_m_err", 32'(bus.m_err), 0);
        chk("rst_m_dat_r", 32'(bus.m_dat_r), 0);
        chk("rst_s_adr", 32'(bus.s_adr), 0);
        tick();
        rst = 1'b0;

        // Master 0 burst read 0..8, ack every cycle.
        for (int a = 0; a < 9; a++) push(0, 1'b0, 8'(a));
        start(0, 8'h00, 1'b0);
        for (int a = 0; a < 9; a++) begin
            m_adr_v[7:0] = 8'(a);
            wait_resp(0, e, n);
            if (a == 0) chk("burst_first_latency", 32'(n), 2);
            else chk("burst_back_to_back", 32'(n), 1);
            tick();
        end
        chk("burst_grant_id", 32'(grant_id), 0);
        stop(0);
        repeat (3) tick();

        // Masters 0 and 1 together: 0 first, then a two-cycle ownerless gap.
        do_reset();
        push(0, 1'b0, 8'h10);
        push(1, 1'b0, 8'h20);
        start(0, 8'h10, 1'b1);
        start(1, 8'h20, 1'b0);
        wait_resp(0, e, n);
        chk("pair_latency", 32'(n), 2);
        chk("pair_s_we", 32'(bus.s_we), 1);
        chk("pair_s_dat_w", 32'(bus.s_dat_w), 32'h10EF);
        tick();
        stop(0);
        gap = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.s_cyc) break;
            if (!busy) gap++;
        end
        chk("pair_gap_cycles", 32'(gap), 2);
        chk("pair_grant_id", 32'(grant_id), 1);
        tick();
        stop(1);
        repeat (3) tick();

        // Three masters requesting continuously: strict rotation.
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int m = 0; m < 3; m++) push(m, 1'b0, 8'h30 + 8'(m * 4 + r));
        fork
            master_proc(0);
            master_proc(1);
            master_proc(2);
        join
        repeat (3) tick();

        // Slave never acks master 2: watchdog error after 15 strobe cycles.
        do_reset();
        ack_delay = 1000;
        push(2, 1'b1, 8'h55);
        start(2, 8'h55, 1'b0);
        start_n = -1;
        err_n = -1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (bus.s_stb && start_n < 0) start_n = k;
            if (bus.m_err[2]) begin
                err_n = k;
                break;
            end
        end
        chk("timeout_cycles", 32'(err_n - start_n), 15);
        chk("timeout_s_cyc", 32'(bus.s_cyc), 0);
        chk("timeout_busy", 32'(busy), 0);
        tick();
        stop(2);
        @(negedge clk);
        chk("timeout_idle_busy", 32'(busy), 0);
        tick();

        // Ack arrives on the limit cycle: ack wins, no error.
        ack_delay = 14;
        push(2, 1'b0, 8'h66);
        start(2, 8'h66, 1'b0);
        wait_resp(2, e, n);
        chk("limit_ack_no_err", 32'(e), 0);
        chk("limit_ack_cycles", 32'(n), 16);
        tick();
        stop(2);
        @(negedge clk);
        chk("limit_err_after", 32'(bus.m_err), 0);
        repeat (2) tick();

        // Reset while master 1 owns with strobe high.
        ack_delay = 1000;
        start(1, 8'h77, 1'b0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (busy && grant_id == 2'd1) break;
        end
        chk("rst_mid_owner", 32'(grant_id), 1);
        tick();
        start(0, 8'h70, 1'b0);
        start(2, 8'h72, 1'b0);
        rst = 1'b1;
        force_ack = 1'b1;
        @(negedge clk);
        chk("rst_mid_ack_blocked", 32'(bus.m_ack), 0);
        tick();
        rst = 1'b0;
        force_ack = 1'b0;
        @(negedge clk);
        chk("rst_mid_s_cyc", 32'(bus.s_cyc), 0);
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_grant_id", 32'(grant_id), 0);
        @(negedge clk);
        chk("rst_mid_regrant_busy", 32'(busy), 1);
        chk("rst_mid_regrant_id", 32'(grant_id), 0);
        tick();
        stop(0);
        stop(1);
        stop(2);
        repeat (3) tick();

        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
